// File: rtl/video_sequencer_pkg.sv
// Control-vector bit indices, dot/line windows and the fetch-phase decoder
// shared by the video sequencer and its datapath consumers.
package video_sequencer_signals;

    localparam int video_fetch_phase_lsb = 0;
    localparam int video_fetch_phase_msb = 7;
    localparam int video_vblank_set      = 8;
    localparam int video_vblank_clr      = 9;
    localparam int video_is_rendering    = 10;
    localparam int video_incr_hori_v     = 11;
    localparam int video_incr_vert_v     = 12;
    localparam int video_hori_v_eq_t     = 13;
    localparam int video_vert_v_eq_t     = 14;
    localparam int video_sprite_fetch    = 15;

    localparam logic [15:0] C_visible_lines = 16'd240;
    localparam logic [15:0] C_vblank_dot    = 16'd1;

    // Background fetch: main line window plus the two-tile prefetch for the next line.
    localparam logic [15:0] C_fetch_lo     = 16'd1;
    localparam logic [15:0] C_fetch_hi     = 16'd256;
    localparam logic [15:0] C_prefetch_lo  = 16'd321;
    localparam logic [15:0] C_prefetch_hi  = 16'd340;

    localparam logic [15:0] C_hori_lo      = 16'd8;
    localparam logic [15:0] C_hori_hi      = 16'd256;
    localparam logic [15:0] C_hori_pre_lo  = 16'd328;
    localparam logic [15:0] C_hori_pre_hi  = 16'd336;
    localparam logic [15:0] C_vert_inc_dot = 16'd256;
    localparam logic [15:0] C_hori_copy    = 16'd257;
    localparam logic [15:0] C_vert_copy_lo = 16'd280;
    localparam logic [15:0] C_vert_copy_hi = 16'd304;
    localparam logic [15:0] C_sprite_lo    = 16'd257;
    localparam logic [15:0] C_sprite_hi    = 16'd320;

    function automatic logic [7:0] decode_phase(input logic [2:0] sel);
        decode_phase = 8'd1 << sel;
    endfunction

endpackage

// File: rtl/video_position_counter.sv
// Dot/line position counters and frame parity, including the shortened
// pre-render line on odd frames while rendering.
module video_position_counter #(
    parameter int unsigned P_dots_per_line   = 341,
    parameter int unsigned P_lines_per_frame = 262,
    parameter int unsigned P_skip_odd_dot    = 1
) (
    input  logic        I_vid_clock,
    input  logic        I_reset,
    input  logic        I_dot_enable,
    input  logic        I_render_enable,
    output logic [15:0] O_hcount,
    output logic [15:0] O_vcount,
    output logic        O_odd_frame,
    output logic        O_pre_render
);

    localparam logic [15:0] L_last_dot  = 16'(P_dots_per_line - 1);
    localparam logic [15:0] L_skip_dot  = 16'(P_dots_per_line - 2);
    localparam logic [15:0] L_last_line = 16'(P_lines_per_frame - 1);
    localparam logic        L_skip_en   = (P_skip_odd_dot != 0);

    logic [15:0] hcount_q, hcount_d;
    logic [15:0] vcount_q, vcount_d;
    logic        odd_q, odd_d;
    logic        pre_render, skip_dot, line_end;

    assign pre_render = (vcount_q == L_last_line);
    assign skip_dot   = L_skip_en & odd_q & I_render_enable & pre_render & (hcount_q == L_skip_dot);
    assign line_end   = (hcount_q == L_last_dot) | skip_dot;

    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        odd_d    = odd_q;
        if (I_dot_enable) begin
            if (line_end) begin
                hcount_d = '0;
                if (pre_render) begin
                    vcount_d = '0;
                    odd_d    = ~odd_q;
                end else begin
                    vcount_d = vcount_q + 16'd1;
                end
            end else begin
                hcount_d = hcount_q + 16'd1;
            end
        end
    end

    always_ff @(posedge I_vid_clock or posedge I_reset) begin
        if (I_reset) begin
            hcount_q <= '0;
            vcount_q <= L_last_line;
            odd_q    <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            odd_q    <= odd_d;
        end
    end

    assign O_hcount     = hcount_q;
    assign O_vcount     = vcount_q;
    assign O_odd_frame  = odd_q;
    assign O_pre_render = pre_render;

endmodule

// File: rtl/video_sequencer.sv
// Dot/line sequencer: position counters, vblank status flag and the per-dot
// control vector for the background fetch and scroll register logic.
module video_sequencer
    import video_sequencer_signals::*;
#(
    parameter int unsigned P_dots_per_line   = 341,
    parameter int unsigned P_lines_per_frame = 262,
    parameter int unsigned P_vblank_line     = 241,
    parameter int unsigned P_skip_odd_dot    = 1
) (
    input  logic        I_vid_clock,
    input  logic        I_reset,
    input  logic        I_dot_enable,
    input  logic        I_render_enable,
    input  logic        I_status_read,
    output logic [15:0] O_hcount,
    output logic [15:0] O_vcount,
    output logic        O_odd_frame,
    output logic        O_vblank_flag,
    output logic        O_frame_start,
    output logic [15:0] O_control
);

    localparam logic [15:0] L_vblank_line = 16'(P_vblank_line);

    logic [15:0] hcount, vcount, control;
    logic        odd_frame, pre_render, visible, render_line;
    logic        in_fetch, in_hori, in_vert_copy, in_sprite;
    logic        vblank_q, vblank_d;

    video_position_counter #(
        .P_dots_per_line   (P_dots_per_line),
        .P_lines_per_frame (P_lines_per_frame),
        .P_skip_odd_dot    (P_skip_odd_dot)
    ) u_pos (
        .I_vid_clock     (I_vid_clock),
        .I_reset         (I_reset),
        .I_dot_enable    (I_dot_enable),
        .I_render_enable (I_render_enable),
        .O_hcount        (hcount),
        .O_vcount        (vcount),
        .O_odd_frame     (odd_frame),
        .O_pre_render    (pre_render)
    );

    assign visible      = (vcount < C_visible_lines);
    assign render_line  = (visible | pre_render) & I_render_enable;
    assign in_fetch     = ((hcount >= C_fetch_lo) && (hcount <= C_fetch_hi)) ||
                          ((hcount >= C_prefetch_lo) && (hcount <= C_prefetch_hi));
    assign in_hori      = ((hcount >= C_hori_lo) && (hcount <= C_hori_hi)) ||
                          ((hcount >= C_hori_pre_lo) && (hcount <= C_hori_pre_hi));
    assign in_vert_copy = (hcount >= C_vert_copy_lo) && (hcount <= C_vert_copy_hi);
    assign in_sprite    = (hcount >= C_sprite_lo) && (hcount <= C_sprite_hi);

    // Bits 11-14 are gated by the dot strobe so each fires once per dot.
    always_comb begin
        control = '0;
        if (render_line && in_fetch)
            control[video_fetch_phase_msb:video_fetch_phase_lsb] = decode_phase(hcount[2:0]);
        control[video_vblank_set]   = (vcount == L_vblank_line) && (hcount == C_vblank_dot);
        control[video_vblank_clr]   = pre_render && (hcount == C_vblank_dot);
        control[video_is_rendering] = render_line;
        control[video_incr_hori_v]  = render_line && (hcount[2:0] == 3'd0) && in_hori && I_dot_enable;
        control[video_incr_vert_v]  = render_line && (hcount == C_vert_inc_dot) && I_dot_enable;
        control[video_hori_v_eq_t]  = render_line && (hcount == C_hori_copy) && I_dot_enable;
        control[video_vert_v_eq_t]  = pre_render && I_render_enable && in_vert_copy && I_dot_enable;
        control[video_sprite_fetch] = render_line && in_sprite;
    end

    // A status read beats a simultaneous set, so that frame's vblank is lost.
    always_comb begin
        vblank_d = vblank_q;
        if (I_dot_enable && control[video_vblank_set]) vblank_d = 1'b1;
        if (I_dot_enable && control[video_vblank_clr]) vblank_d = 1'b0;
        if (I_status_read) vblank_d = 1'b0;
    end

    always_ff @(posedge I_vid_clock or posedge I_reset) begin
        if (I_reset) vblank_q <= 1'b0;
        else         vblank_q <= vblank_d;
    end

    assign O_hcount      = hcount;
    assign O_vcount      = vcount;
    assign O_odd_frame   = odd_frame;
    assign O_vblank_flag = vblank_q;
    assign O_frame_start = (hcount == 16'd0) && (vcount == 16'd0);
    assign O_control     = control;

endmodule

// File: tb/tb_video_sequencer.sv
// Directed bench for video_sequencer: NTSC/PAL decode table walked in lockstep,
// plus a small-geometry pair for frame length, odd-dot skip and vblank races.
module tb_video_sequencer;
    import video_sequencer_signals::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nt_rst, nt_en, nt_ren, nt_rd;
    logic [15:0] nt_h, nt_v, nt_ctl, pa_h, pa_v, pa_ctl;
    logic        nt_odd, nt_vb, nt_fs, pa_odd, pa_vb, pa_fs;

    logic        s_rst, s_en, s_ren, s_rd;
    logic [15:0] s_h, s_v, s_ctl, n_h, n_v, n_ctl;
    logic        s_odd, s_vb, s_fs, n_odd, n_vb, n_fs;

    video_sequencer u_ntsc (
        .I_vid_clock(clk), .I_reset(nt_rst), .I_dot_enable(nt_en), .I_render_enable(nt_ren),
        .I_status_read(nt_rd), .O_hcount(nt_h), .O_vcount(nt_v), .O_odd_frame(nt_odd),
        .O_vblank_flag(nt_vb), .O_frame_start(nt_fs), .O_control(nt_ctl));

    video_sequencer #(.P_lines_per_frame(312)) u_pal (
        .I_vid_clock(clk), .I_reset(nt_rst), .I_dot_enable(nt_en), .I_render_enable(nt_ren),
        .I_status_read(nt_rd), .O_hcount(pa_h), .O_vcount(pa_v), .O_odd_frame(pa_odd),
        .O_vblank_flag(pa_vb), .O_frame_start(pa_fs), .O_control(pa_ctl));

    video_sequencer #(.P_dots_per_line(20), .P_lines_per_frame(10), .P_vblank_line(5),
                      .P_skip_odd_dot(1)) u_small (
        .I_vid_clock(clk), .I_reset(s_rst), .I_dot_enable(s_en), .I_render_enable(s_ren),
        .I_status_read(s_rd), .O_hcount(s_h), .O_vcount(s_v), .O_odd_frame(s_odd),
        .O_vblank_flag(s_vb), .O_frame_start(s_fs), .O_control(s_ctl));

    video_sequencer #(.P_dots_per_line(20), .P_lines_per_frame(10), .P_vblank_line(5),
                      .P_skip_odd_dot(0)) u_noskip (
        .I_vid_clock(clk), .I_reset(s_rst), .I_dot_enable(s_en), .I_render_enable(s_ren),
        .I_status_read(s_rd), .O_hcount(n_h), .O_vcount(n_v), .O_odd_frame(n_odd),
        .O_vblank_flag(n_vb), .O_frame_start(n_fs), .O_control(n_ctl));

    typedef struct {
        logic [15:0] v;
        logic [15:0] pv;
        logic [15:0] h;
        logic        ren;
        logic [15:0] ctl;
        logic        fs;
    } vec_t;

    vec_t vecs[17];

    int total = 0;
    int bad   = 0;
    int cnt_hori10 = 0, cnt_vert10 = 0, cnt_heqt10 = 0, cnt_spr10 = 0;
    int cnt_veqt_pre = 0, cnt_clr_pre = 0, cnt_l100 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        if (nt_en) begin
            if (nt_v == 16'd10) begin
                if (nt_ctl[video_incr_hori_v])  cnt_hori10++;
                if (nt_ctl[video_incr_vert_v])  cnt_vert10++;
                if (nt_ctl[video_hori_v_eq_t])  cnt_heqt10++;
                if (nt_ctl[video_sprite_fetch]) cnt_spr10++;
            end
            if (nt_v == 16'd261) begin
                if (nt_ctl[video_vert_v_eq_t]) cnt_veqt_pre++;
                if (nt_ctl[video_vblank_clr])  cnt_clr_pre++;
            end
            if (nt_v == 16'd100 && (nt_ctl[video_vert_v_eq_t] || nt_ctl[video_vblank_clr]))
                cnt_l100++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic seek_nt(input logic [15:0] v, input logic [15:0] h);
        int g = 0;
        while (!(nt_v == v && nt_h == h) && g < 40000) begin
            tick();
            g++;
        end
        chk("seek_ntsc", {nt_v, nt_h}, {v, h});
    endtask

    task automatic seek_s(input logic [15:0] v, input logic [15:0] h);
        int g = 0;
        while (!(s_v == v && s_h == h) && g < 1000) begin
            tick();
            g++;
        end
        chk("seek_small", {s_v, s_h}, {v, h});
    endtask

    // Dots until each small instance next shows frame_start, and the position just before it.
    task automatic measure(output int ls, output int ln, output logic [31:0] ps, output logic [31:0] pn);
        logic [31:0] cs, cn;
        ls = 0; ln = 0; ps = '0; pn = '0;
        for (int k = 1; k <= 400 && (ls == 0 || ln == 0); k++) begin
            cs = {s_v, s_h};
            cn = {n_v, n_h};
            tick();
            if (ls == 0 && s_fs) begin ls = k; ps = cs; end
            if (ln == 0 && n_fs) begin ln = k; pn = cn; end
        end
    endtask

    initial begin
        int ls, ln;
        logic [31:0] ps, pn;

        vecs[0]  = '{16'd261, 16'd311, 16'd0,   1'b1, 16'h0400, 1'b0};
        vecs[1]  = '{16'd261, 16'd311, 16'd1,   1'b1, 16'h0602, 1'b0};
        vecs[2]  = '{16'd261, 16'd311, 16'd280, 1'b1, 16'hC400, 1'b0};
        vecs[3]  = '{16'd261, 16'd311, 16'd304, 1'b1, 16'hC400, 1'b0};
        vecs[4]  = '{16'd261, 16'd311, 16'd305, 1'b1, 16'h8400, 1'b0};
        vecs[5]  = '{16'd261, 16'd311, 16'd328, 1'b1, 16'h0C01, 1'b0};
        vecs[6]  = '{16'd0,   16'd0,   16'd0,   1'b1, 16'h0400, 1'b1};
        vecs[7]  = '{16'd10,  16'd10,  16'd7,   1'b1, 16'h0480, 1'b0};
        vecs[8]  = '{16'd10,  16'd10,  16'd8,   1'b1, 16'h0C01, 1'b0};
        vecs[9]  = '{16'd10,  16'd10,  16'd256, 1'b1, 16'h1C01, 1'b0};
        vecs[10] = '{16'd10,  16'd10,  16'd257, 1'b1, 16'hA400, 1'b0};
        vecs[11] = '{16'd10,  16'd10,  16'd320, 1'b1, 16'h8400, 1'b0};
        vecs[12] = '{16'd10,  16'd10,  16'd321, 1'b1, 16'h0402, 1'b0};
        vecs[13] = '{16'd10,  16'd10,  16'd340, 1'b1, 16'h0410, 1'b0};
        vecs[14] = '{16'd11,  16'd11,  16'd100, 1'b0, 16'h0000, 1'b0};
        vecs[15] = '{16'd100, 16'd100, 16'd1,   1'b1, 16'h0402, 1'b0};
        vecs[16] = '{16'd100, 16'd100, 16'd290, 1'b1, 16'h8400, 1'b0};

        nt_rst = 1'b1; nt_en = 1'b0; nt_ren = 1'b1; nt_rd = 1'b0;
        s_rst  = 1'b1; s_en  = 1'b0; s_ren  = 1'b0; s_rd  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nt_rst = 1'b0;
        s_rst  = 1'b0;
        #1;

        chk("ntsc_reset_odd", nt_odd, 1'b0);
        chk("ntsc_reset_vblank", nt_vb, 1'b0);
        chk("pal_reset_pos", {pa_v, pa_h}, {16'd311, 16'd0});

        nt_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            seek_nt(vecs[i].v, vecs[i].h);
            nt_ren = vecs[i].ren;
            #1;
            chk($sformatf("vec%0d_ctl", i), nt_ctl, vecs[i].ctl);
            chk($sformatf("vec%0d_fs", i), nt_fs, vecs[i].fs);
            chk($sformatf("vec%0d_pal_pos", i), {pa_v, pa_h}, {vecs[i].pv, vecs[i].h});
            chk($sformatf("vec%0d_pal_ctl", i), pa_ctl, vecs[i].ctl);
        end

        chk("line10_incr_hori_cnt", cnt_hori10, 34);
        chk("line10_incr_vert_cnt", cnt_vert10, 1);
        chk("line10_hori_eq_cnt", cnt_heqt10, 1);
        chk("line10_sprite_cnt", cnt_spr10, 64);
        chk("pre_vert_eq_cnt", cnt_veqt_pre, 25);
        chk("pre_vblank_clr_cnt", cnt_clr_pre, 1);
        chk("line100_pre_only_cnt", cnt_l100, 0);
        chk("ntsc_odd_after_wrap", nt_odd, 1'b1);
        chk("pal_odd_after_wrap", pa_odd, 1'b1);

        // Asynchronous reset mid-line 100, seen without a clock edge.
        nt_rst = 1'b1;
        #1;
        chk("rst_ntsc_pos", {nt_v, nt_h}, {16'd261, 16'd0});
        chk("rst_pal_pos", {pa_v, pa_h}, {16'd311, 16'd0});
        chk("rst_pal_odd", pa_odd, 1'b0);
        chk("rst_pal_vblank", pa_vb, 1'b0);
        chk("rst_pal_fs", pa_fs, 1'b0);
        chk("rst_ctl_render_on", nt_ctl, 16'h0400);
        @(posedge clk);
        #1;
        chk("rst_held_pos", {pa_v, pa_h}, {16'd311, 16'd0});
        nt_ren = 1'b0;
        #1;
        chk("rst_ctl_render_off", pa_ctl, 16'h0000);
        nt_rst = 1'b0;
        nt_en  = 1'b0;

        // Small geometry: 20 dots x 10 lines, vblank on line 5.
        chk("small_reset_pos", {s_v, s_h}, {16'd9, 16'd0});
        chk("small_reset_ctl", s_ctl, 16'h0000);
        s_en = 1'b1;
        measure(ls, ln, ps, pn);
        chk("first_fs_small", ls, 20);
        chk("first_fs_noskip", ln, 20);
        chk("odd_after_first", {s_odd, n_odd}, 2'b11);
        measure(ls, ln, ps, pn);
        chk("frame_off_small", ls, 200);
        chk("frame_off_noskip", ln, 200);
        chk("odd_after_off", {s_odd, n_odd}, 2'b00);
        s_ren = 1'b1;
        measure(ls, ln, ps, pn);
        chk("frame_even_small", ls, 200);
        chk("frame_even_noskip", ln, 200);
        measure(ls, ln, ps, pn);
        chk("frame_odd_small", ls, 199);
        chk("frame_odd_noskip", ln, 200);
        chk("skip_prev_pos", ps, {16'd9, 16'd18});
        chk("noskip_prev_pos", pn, {16'd9, 16'd19});

        // Read in the same cycle as the set: flag must stay clear all frame.
        seek_s(16'd5, 16'd1);
        chk("vbset_ctl", s_ctl, 16'h0502);
        s_rd = 1'b1;
        tick();
        s_rd = 1'b0;
        chk("race_flag", s_vb, 1'b0);
        tick();
        chk("race_flag_later", s_vb, 1'b0);

        // Frozen dot strobe must not set the flag; set lands one clock later.
        seek_s(16'd5, 16'd1);
        s_en = 1'b0;
        tick();
        tick();
        chk("freeze_pos", {s_v, s_h}, {16'd5, 16'd1});
        chk("freeze_flag", s_vb, 1'b0);
        s_en = 1'b1;
        tick();
        chk("set_flag", s_vb, 1'b1);
        s_rd = 1'b1;
        tick();
        s_rd = 1'b0;
        chk("read_clears", s_vb, 1'b0);

        // Flag survives to pre-render and is cleared at dot 1.
        seek_s(16'd5, 16'd2);
        chk("set_again", s_vb, 1'b1);
        seek_s(16'd9, 16'd1);
        chk("flag_before_clr", s_vb, 1'b1);
        chk("clr_ctl", s_ctl, 16'h0602);
        tick();
        chk("clr_flag", s_vb, 1'b0);

        seek_s(16'd9, 16'd8);
        chk("strobe_ctl_en", s_ctl, 16'h0C01);
        s_en = 1'b0;
        #1;
        chk("strobe_ctl_noen", s_ctl, 16'h0401);
        s_en = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_sequencer.md
# video_sequencer

Parametrised successor to the fixed NTSC video control decoder. It owns the dot/line position counters, the odd-frame state and the vblank status flag, and decodes the 16-bit per-dot control vector that drives the background fetch pipeline and the scroll (v/t) register logic. It sits between the pixel clock-enable generator and the video fetch/scroll datapath, and supports both NTSC and PAL frame geometry through parameters.

## Interface
- P_dots_per_line, 341, dots per line; hcount wraps at P_dots_per_line-1
- P_lines_per_frame, 262, lines per frame (312 for PAL); the last line is the pre-render line
- P_vblank_line, 241, line on which vblank is entered
- P_skip_odd_dot, 1, 1 = skip the last pre-render dot on odd frames while rendering is enabled
- I_vid_clock  in  1  video clock
- I_reset  in  1  reset, asynchronous, active-high
- I_dot_enable  in  1  one-cycle dot strobe; all state advances only when it is high
- I_render_enable  in  1  background or sprite rendering enabled (from mask register)
- I_status_read  in  1  one-cycle strobe: CPU read of the status register
- O_hcount  out  16  current dot, 0..P_dots_per_line-1
- O_vcount  out  16  current line, 0..P_lines_per_frame-1
- O_odd_frame  out  1  frame parity
- O_vblank_flag  out  1  status-register vblank bit
- O_frame_start  out  1  high for the dot period at (0,0)
- O_control  out  16  control vector; bit indices are defined in video_sequencer_signals

## Operation
- Derived conditions: pre-render = vcount==P_lines_per_frame-1; visible = vcount<240; render_line = (visible|pre-render) & I_render_enable.
- Counters: on I_dot_enable, hcount increments. At P_dots_per_line-1, hcount wraps to 0 and vcount increments, wrapping to 0 after the pre-render line. odd_frame toggles on each wrap to line 0.
- Odd skip: if P_skip_odd_dot & odd_frame & I_render_enable & pre-render & hcount==P_dots_per_line-2, the next dot is (0,0). The flag values are sampled on that same enabled cycle.
- Control bits [7:0], fetch phase one-hot of hcount[2:0]: asserted only when render_line and hcount is in 1..256 or 321..340.
- Bit 8, vblank_set: vcount==P_vblank_line & hcount==1.
- Bit 9, vblank_clr: pre-render & hcount==1.
- Bit 10, is_rendering: render_line.
- Bit 11, incr_hori_v: render_line & hcount[2:0]==0 & (hcount in 8..256 or 328..336) & I_dot_enable.
- Bit 12, incr_vert_v: render_line & hcount==256 & I_dot_enable.
- Bit 13, hori_v_eq_t: render_line & hcount==257 & I_dot_enable.
- Bit 14, vert_v_eq_t: pre-render & I_render_enable & hcount in 280..304 & I_dot_enable.
- Bit 15, sprite_fetch: render_line & hcount in 257..320.
- Bits 8-10 and 15 are level signals for the whole dot period. Bits 11-14 are single-cycle strobes.
- Vblank flag:
  - Set on the enabled cycle where bit 8 is high.
  - Cleared on the enabled cycle where bit 9 is high.
  - Cleared by I_status_read on any cycle.
  - If I_status_read and the set condition occur in the same cycle, the flag stays 0. The read wins, and that set is lost for the frame.
- I_render_enable changes take effect on the next decode; counters never stall.

## Timing
- Reset values: hcount 0, vcount P_lines_per_frame-1 (pre-render), odd_frame 0, vblank_flag 0. O_frame_start is 0 (position is not (0,0)). Level bits 8/15 are 0, bit 10 = I_render_enable, strobes 0.
- Reset asserted mid-frame returns immediately to the reset values, independent of I_dot_enable.
- Counters, odd_frame and vblank_flag are registers that update on the rising I_vid_clock edge when enabled. O_control and O_frame_start are combinational decodes of the registered state plus inputs, so they are valid in the same cycle as the position they describe.
- O_vblank_flag changes one clock after the qualifying enabled cycle.
- I_dot_enable held high continuously gives one dot per clock; held low freezes all state.

## Structure
- Package video_sequencer_signals contains:
  - the bit indices 0..15, reusing the existing fetch/vblank/scroll index values and adding video_sprite_fetch = 15;
  - constants for visible line count (240), fetch windows and copy windows.
- Sub-module video_position_counter: hcount/vcount/odd_frame with the skip logic. The existing decoder (P_width 3) is reused for the fetch phase one-hot.
- The top level contains the window decode and the vblank flag.

## Test plan
- Reset, then 341*262 enabled dots with rendering off: frame_start again after exactly 89342 dots; odd_frame toggles; no skip occurs.
- Rendering on, two frames: the odd frame is 89341 dots and the even frame is 89342; (261,339)→(0,0) on the odd frame only. With P_skip_odd_dot=0, both frames are 89342.
- Line 10, rendering on: incr_hori_v pulses at dots 8,16,…,256 and 328,336 (34 pulses); incr_vert_v at 256; hori_v_eq_t at 257; sprite_fetch is high for 257..320.
- Pre-render line: vblank_clr at dot 1 clears the flag; vert_v_eq_t pulses for 25 dots (280..304); none of these on line 100.
- Vblank race: I_status_read in the same cycle as (241,1) leaves the flag at 0. A read at (241,2) clears a flag that was set to 1.
- PAL (P_lines_per_frame=312): the pre-render line is 311, vblank_set occurs at line 241, and frame length is 341*312 dots. Reset asserted mid-line 100 returns to (311,0) with the flag cleared.
